// File: rtl/led_wb_frame_fetcher.sv
// Wishbone read master that streams one LED frame buffer into a show-ahead
// prefetch FIFO. Keeps at most FIFO_DEPTH words buffered or in flight, can
// wrap around the buffer, and aborts cleanly on a bus timeout.
module led_wb_frame_fetcher #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int BUF_ID_WIDTH = 2,
   parameter int BUF_WORDS    = 64,
   parameter int BASE_ADDR    = 0,
   parameter int FIFO_DEPTH   = 4,
   parameter int WB_TIMEOUT   = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic [ADDR_WIDTH-1:0]   wbm_address,
   output logic [DATA_WIDTH-1:0]   wbm_writedata,
   input  logic [DATA_WIDTH-1:0]   wbm_readdata,
   output logic                    wbm_strobe,
   output logic                    wbm_cycle,
   output logic                    wbm_write,
   input  logic                    wbm_ack,
   input  logic [BUF_ID_WIDTH-1:0] buf_id,
   input  logic                    loop,
   input  logic                    start,
   input  logic                    next,
   output logic                    word_valid,
   output logic [DATA_WIDTH-1:0]   word,
   output logic                    word_last,
   output logic                    busy,
   output logic                    err
);

   localparam int IDX_W = $clog2(BUF_WORDS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(WB_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BUS,
      S_DONE
   } state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_t                  state_q, state_n;
   logic [IDX_W-1:0]        idx_q;
   logic [BUF_ID_WIDTH-1:0] buf_q;
   logic                    loop_q;
   logic                    err_q;
   logic                    cyc_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [TMO_W-1:0]        tmo_q;
   logic                    discard_q;
   logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]        count_q;
   entry_t                  mem_q [FIFO_DEPTH];
   entry_t                  head;

   logic                    idx_last, ack_ev, tmo_hit, fifo_empty, can_issue;
   logic                    push, pop, flush, idx_adv, err_set;
   logic [ADDR_WIDTH-1:0]   addr_calc;

   assign idx_last   = (idx_q == IDX_W'(BUF_WORDS - 1));
   assign ack_ev     = (state_q == S_BUS) && wbm_ack;
   assign tmo_hit    = (state_q == S_BUS) && !wbm_ack && (tmo_q == TMO_W'(WB_TIMEOUT - 1));
   assign fifo_empty = (count_q == '0);
   // Credit is the FIFO fill: ISSUE is only ever reached with no read outstanding.
   assign can_issue  = (count_q < CNT_W'(FIFO_DEPTH));
   // Wraps modulo 2^ADDR_WIDTH by truncation.
   assign addr_calc  = ADDR_WIDTH'(BASE_ADDR)
                     + ADDR_WIDTH'(buf_q) * ADDR_WIDTH'(BUF_WORDS)
                     + ADDR_WIDTH'(idx_q);

   // Next-state and datapath control; start overrides everything else.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_n = state_q;
      push    = 1'b0;
      pop     = next && !fifo_empty;
      flush   = 1'b0;
      idx_adv = 1'b0;
      err_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_n = S_IDLE;
         end
         S_ISSUE: begin
            if (can_issue) state_n = S_BUS;
         end
         S_BUS: begin
            if (ack_ev) begin
               if (discard_q) begin
                  state_n = S_ISSUE;
               end else begin
                  push    = 1'b1;
                  idx_adv = 1'b1;
                  state_n = (idx_last && !loop_q) ? S_DONE : S_ISSUE;
               end
            end else if (tmo_hit) begin
               state_n = S_IDLE;
               flush   = 1'b1;
               err_set = 1'b1;
            end
         end
         S_DONE: begin
            if (fifo_empty || (count_q == CNT_W'(1) && pop)) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (start) begin
         flush   = 1'b1;
         push    = 1'b0;
         pop     = 1'b0;
         idx_adv = 1'b0;
         err_set = 1'b0;
         // A bus cycle in progress is never cut short; its data is discarded.
         state_n = (state_q == S_BUS && !ack_ev && !tmo_hit) ? S_BUS : S_ISSUE;
      end
   end

   // State, bus, fetch-index and FIFO pointer registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         buf_q     <= '0;
         loop_q    <= 1'b0;
         err_q     <= 1'b0;
         cyc_q     <= 1'b0;
         addr_q    <= '0;
         tmo_q     <= '0;
         discard_q <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_n;
         cyc_q   <= (state_n == S_BUS);

         if (state_q != S_BUS && state_n == S_BUS) begin
            addr_q <= addr_calc;
            tmo_q  <= '0;
         end else if (state_q == S_BUS) begin
            tmo_q  <= tmo_q + TMO_W'(1);
         end

         if (start && state_n == S_BUS) discard_q <= 1'b1;
         else if (ack_ev || tmo_hit)    discard_q <= 1'b0;

         if (start) begin
            buf_q  <= buf_id;
            loop_q <= loop;
            idx_q  <= '0;
            err_q  <= 1'b0;
         end else begin
            if (idx_adv) idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
            if (err_set) err_q <= 1'b1;
         end

         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // FIFO storage write on the ack edge.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the count and pointers alone define its contents.
      if (push) mem_q[wr_ptr_q] <= {idx_last, wbm_readdata};
   end

   assign head          = mem_q[rd_ptr_q];
   assign word_valid    = !fifo_empty;
   assign word          = word_valid ? head.data : '0;
   assign word_last     = word_valid && head.last;
   assign busy          = (state_q != S_IDLE);
   assign err           = err_q;
   assign wbm_cycle     = cyc_q;
   assign wbm_strobe    = cyc_q;
   assign wbm_address   = addr_q;
   assign wbm_write     = 1'b0;
   assign wbm_writedata = '0;

endmodule
